rv32i_multicycle_control: RTL and testbench

Main control state machine for the multi-cycle RV32I datapath. Decodes the 7-bit opcode of the fetched instruction and sequences fetch, decode, execute, memory and write-back one step per clock. It drives the datapath mux selects, the register-file and PC write enables, and the 3-bit `ALUOp` consumed by `ALUControl`. A memory request/ready handshake and a retired-instruction counter are included.

---
 rtl/rv32i_multicycle_control_if.sv | 32 +++
 rtl/rv32i_multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_rv32i_multicycle_control.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_multicycle_control_if.sv
// rtl/rv32i_multicycle_control_if.sv - control/datapath/memory signal bundle for the multi-cycle RV32I controller
interface rv32i_multicycle_control_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] ALUOp;
    logic       reg_write;
    logic [1:0] result_src;

    modport master (
        input  opcode, func3, zero, lt, ltu, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, ALUOp, reg_write, result_src
    );

    modport slave (
        output opcode, func3, zero, lt, ltu, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, ALUOp, reg_write, result_src
    );
endinterface

// File: rtl/rv32i_multicycle_control.sv
// rtl/rv32i_multicycle_control.sv - main FSM sequencing fetch/decode/execute/memory/write-back for RV32I
module rv32i_multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rv32i_multicycle_control_if.master  bus,
    output logic                        retire,
    output logic [CNT_W-1:0]            retire_cnt,
    output logic                        illegal
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXR,
        EXI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t state, state_nxt;
    logic   taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    // funct3 010/011 are not RV32I branches and simply fall through
    always_comb begin
        taken = 1'b0;
        case (bus.func3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = !bus.zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = !bus.lt;
            3'b110:  taken = bus.ltu;
            3'b111:  taken = !bus.ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.ALUOp      = 3'b000;
        bus.reg_write  = 1'b0;
        bus.result_src = 2'b00;
        retire         = 1'b0;
        illegal        = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_nxt    = DECODE;
                end
            end
            DECODE: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b10;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_nxt = MEMADR;
                    OP_R:              state_nxt = EXR;
                    OP_I:              state_nxt = EXI;
                    OP_BRANCH:         state_nxt = BRANCH;
                    OP_JAL:            state_nxt = JAL;
                    OP_JALR:           state_nxt = JALR;
                    OP_LUI:            state_nxt = LUI;
                    OP_AUIPC:          state_nxt = AUIPC;
                    default:           state_nxt = TRAP;
                endcase
            end
            MEMADR: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                state_nxt     = (bus.opcode == OP_LOAD) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt = MEMWB;
                end
            end
            MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.result_src = 2'b01;
                retire         = 1'b1;
                state_nxt      = FETCH;
            end
            MEMWR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            EXR: begin
                bus.alu_src_a = 2'b01;
                bus.ALUOp     = 3'b010;
                state_nxt     = ALUWB;
            end
            EXI: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.ALUOp     = 3'b011;
                state_nxt     = ALUWB;
            end
            ALUWB: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
                state_nxt     = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a = 2'b01;
                bus.ALUOp     = 3'b001;
                bus.pc_src    = 2'b01;
                bus.pc_write  = taken;
                retire        = 1'b1;
                state_nxt     = FETCH;
            end
            JAL: begin
                bus.reg_write  = 1'b1;
                bus.result_src = 2'b10;
                bus.pc_write   = 1'b1;
                bus.pc_src     = 2'b01;
                retire         = 1'b1;
                state_nxt      = FETCH;
            end
            JALR: begin
                bus.alu_src_a  = 2'b01;
                bus.alu_src_b  = 2'b10;
                bus.pc_src     = 2'b10;
                bus.pc_write   = 1'b1;
                bus.reg_write  = 1'b1;
                bus.result_src = 2'b10;
                retire         = 1'b1;
                state_nxt      = FETCH;
            end
            LUI: begin
                bus.alu_src_b = 2'b10;
                bus.ALUOp     = 3'b100;
                state_nxt     = ALUWB;
            end
            AUIPC: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b10;
                state_nxt     = ALUWB;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// tb/tb_rv32i_multicycle_control.sv - randomized instruction-sequence bench for rv32i_multicycle_control
module tb_rv32i_multicycle_control;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        retire, retire4, illegal, illegal4;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
    logic [31:0] mcnt;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    rv32i_multicycle_control_if bus ();
    rv32i_multicycle_control_if bus4 ();

    assign bus4.opcode    = bus.opcode;
    assign bus4.func3     = bus.func3;
    assign bus4.zero      = bus.zero;
    assign bus4.lt        = bus.lt;
    assign bus4.ltu       = bus.ltu;
    assign bus4.mem_ready = bus.mem_ready;

    rv32i_multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .retire(retire), .retire_cnt(cnt), .illegal(illegal)
    );

    rv32i_multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4),
        .retire(retire4), .retire_cnt(cnt4), .illegal(illegal4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word: {req,we,iord,irw,pcw,pcsrc,a,b,aluop,rw,rsrc,retire,illegal}
    function automatic logic [18:0] mk(input int req, input int we, input int iord, input int irw,
                                       input int pcw, input int pcs, input int a, input int b,
                                       input int op, input int rw, input int rs, input int ret,
                                       input int ill);
        return {1'(req), 1'(we), 1'(iord), 1'(irw), 1'(pcw), 2'(pcs), 2'(a), 2'(b),
                3'(op), 1'(rw), 2'(rs), 1'(ret), 1'(ill)};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
                bus.alu_src_a, bus.alu_src_b, bus.ALUOp, bus.reg_write, bus.result_src,
                retire, illegal};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Called just after a falling edge: drive, sample, then advance one full cycle.
    task automatic step(input string tag, input logic [18:0] e, input logic rdy);
        bus.mem_ready = rdy;
        #1;
        check(tag, {13'd0, obs()}, {13'd0, e});
        check({tag, "_cnt"}, cnt, mcnt);
        check({tag, "_cnt4"}, {28'd0, cnt4}, {28'd0, mcnt[3:0]});
        if (e[1]) mcnt = mcnt + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
        case (f3)
            3'b000: return z;
            3'b001: return !z;
            3'b100: return l;
            3'b101: return !l;
            3'b110: return lu;
            3'b111: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int wf, input int wm,
                             input logic z, input logic l, input logic lu);
        bus.opcode = 7'($urandom);
        bus.func3  = f3;
        bus.zero   = z;
        bus.lt     = l;
        bus.ltu    = lu;
        for (int i = 0; i < wf; i++) step("fetch_wait", mk(1,0,0,0,0,0,0,1,0,0,0,0,0), 1'b0);
        step("fetch", mk(1,0,0,1,1,0,0,1,0,0,0,0,0), 1'b1);
        bus.opcode = op;
        step("decode", mk(0,0,0,0,0,0,2,2,0,0,0,0,0), rnd());
        case (op)
            OP_LOAD: begin
                step("memadr", mk(0,0,0,0,0,0,1,2,0,0,0,0,0), rnd());
                for (int i = 0; i < wm; i++) step("memrd_wait", mk(1,0,1,0,0,0,0,0,0,0,0,0,0), 1'b0);
                step("memrd", mk(1,0,1,0,0,0,0,0,0,0,0,0,0), 1'b1);
                step("memwb", mk(0,0,0,0,0,0,0,0,0,1,1,1,0), rnd());
            end
            OP_STORE: begin
                step("memadr", mk(0,0,0,0,0,0,1,2,0,0,0,0,0), rnd());
                for (int i = 0; i < wm; i++) step("memwr_wait", mk(1,1,1,0,0,0,0,0,0,0,0,0,0), 1'b0);
                step("memwr", mk(1,1,1,0,0,0,0,0,0,0,0,1,0), 1'b1);
            end
            OP_R: begin
                step("exr", mk(0,0,0,0,0,0,1,0,2,0,0,0,0), rnd());
                step("aluwb", mk(0,0,0,0,0,0,0,0,0,1,0,1,0), rnd());
            end
            OP_I: begin
                step("exi", mk(0,0,0,0,0,0,1,2,3,0,0,0,0), rnd());
                step("aluwb", mk(0,0,0,0,0,0,0,0,0,1,0,1,0), rnd());
            end
            OP_BRANCH: begin
                step("branch", mk(0,0,0,0,int'(branch_taken(f3, z, l, lu)),1,1,0,1,0,0,1,0), rnd());
            end
            OP_JAL:  step("jal", mk(0,0,0,0,1,1,0,0,0,1,2,1,0), rnd());
            OP_JALR: step("jalr", mk(0,0,0,0,1,2,1,2,0,1,2,1,0), rnd());
            OP_LUI: begin
                step("lui", mk(0,0,0,0,0,0,0,2,4,0,0,0,0), rnd());
                step("aluwb", mk(0,0,0,0,0,0,0,0,0,1,0,1,0), rnd());
            end
            OP_AUIPC: begin
                step("auipc", mk(0,0,0,0,0,0,2,2,0,0,0,0,0), rnd());
                step("aluwb", mk(0,0,0,0,0,0,0,0,0,1,0,1,0), rnd());
            end
            default: begin
                for (int i = 0; i < 20; i++) step("trap", mk(0,0,0,0,0,0,0,0,0,0,0,0,1), rnd());
            end
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_out", {13'd0, obs()}, 32'd0);
        check("reset_cnt", cnt, 32'd0);
        check("reset_cnt4", {28'd0, cnt4}, 32'd0);
        mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step("idle", 19'd0, rnd());
    endtask

    initial begin
        logic [6:0] ops [9];
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        bus.opcode = '0; bus.func3 = '0; bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;
        bus.mem_ready = 1'b0;
        mcnt = 0;
        @(negedge clk);
        @(negedge clk);
        do_reset();

        run_instr(OP_R, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(OP_LOAD, 3'd2, 3, 3, 1'b0, 1'b0, 1'b0);
        run_instr(OP_BRANCH, 3'b000, 0, 0, 1'b1, 1'b0, 1'b0);
        run_instr(OP_BRANCH, 3'b000, 0, 0, 1'b0, 1'b1, 1'b1);
        run_instr(OP_BRANCH, 3'b110, 0, 0, 1'b0, 1'b0, 1'b1);
        run_instr(OP_BRANCH, 3'b010, 0, 0, 1'b1, 1'b1, 1'b1);

        do_reset();
        run_instr(OP_I, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(OP_STORE, 3'd2, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(OP_JAL, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(OP_JALR, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(OP_LUI, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(OP_AUIPC, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("seq_cnt", cnt, 32'd6);

        // Enough random retirements to wrap the 4-bit counter several times
        for (int n = 0; n < 60; n++) begin
            run_instr(ops[$urandom_range(0, 8)], 3'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), rnd(), rnd(), rnd());
        end

        // Abort a store mid-request: reset must drop every output at once
        bus.func3 = 3'd2;
        step("fetch", mk(1,0,0,1,1,0,0,1,0,0,0,0,0), 1'b1);
        bus.opcode = OP_STORE;
        step("decode", mk(0,0,0,0,0,0,2,2,0,0,0,0,0), 1'b0);
        step("memadr", mk(0,0,0,0,0,0,1,2,0,0,0,0,0), 1'b0);
        bus.mem_ready = 1'b1;
        do_reset();
        bus.mem_ready = 1'b0;

        run_instr(OP_BAD, 3'd0, 1, 0, 1'b0, 1'b0, 1'b0);
        check("trap_illegal", {31'd0, illegal}, 32'd1);
        do_reset();
        check("post_trap_illegal", {31'd0, illegal}, 32'd0);
        run_instr(OP_R, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
